dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port 8-bit data memory of the RISC-V pipeline. Shares the memory between the pipeline MEM stage (core) and the program/data loader port used to preload memory before or during execution. Serialises accesses through a small FSM, hides the memory's read latency behind a request/grant/response handshake, and raises a stall toward the pipeline while the core's access is outstanding.

---
 rtl/dmem_arbiter_if.sv | 55 +++++
 rtl/dmem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the three buses around the data-memory arbiter:
//   core_*  : pipeline MEM-stage request / grant / response
//   ldr_*   : program/data loader request / grant / response
//   mem_*   : single-port data memory command and read data
// Modports:
//   slave  : the arbiter (takes requests, drives grants and the memory)
//   master : the environment (requesters plus the memory itself)
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt;
  logic              ldr_rvalid;
  logic [DATA_W-1:0] ldr_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata, core_stall,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_gnt, ldr_rvalid, ldr_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata, core_stall,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_gnt, ldr_rvalid, ldr_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the pipeline MEM stage (core)
// and the loader. One command at a time goes through IDLE -> ISSUE ->
// (WAIT -> RESP for reads) -> IDLE. The memory read latency is hidden
// behind gnt/rvalid pulses, and core_stall freezes the pipeline while the
// core access is outstanding.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous, active-low
//   bus    : dmem_arbiter_if.slave (core, loader and memory buses)
// Parameters: ADDR_W, DATA_W, MEM_LAT (memory read latency, 1..4)
// Build option: define DMEM_ARB_CORE_PRIO_EN for fixed core priority;
//   otherwise ties are resolved round-robin on a last-owner pointer.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic            clock,
  input  logic            reset,
  dmem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);

  state_t            state_reg, state_next;
  logic              owner_reg;          // 0 = core, 1 = loader
  logic              cmd_we_reg;
  logic [ADDR_W-1:0] cmd_addr_reg;
  logic [DATA_W-1:0] cmd_wdata_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_dec;
  logic              any_req;
  logic              winner;             // 0 = core, 1 = loader
  logic              last_wait;
  logic [1:0]        gnt_vec;            // [0] core, [1] loader
  logic [1:0]        rvalid_vec;

  assign any_req   = bus.core_req | bus.ldr_req;
  assign cnt_dec   = cnt_reg - CNT_W'(1);
  // Final WAIT cycle: the counter is about to reach zero and mem_rdata holds
  // the read result.
  assign last_wait = (state_reg == WAIT) && (cnt_dec == '0);

`ifdef DMEM_ARB_CORE_PRIO_EN
  assign winner = ~bus.core_req;
`else
  logic last_owner_reg;

  // On a tie the port that did not own the previous command wins.
  assign winner = (bus.core_req & bus.ldr_req) ? ~last_owner_reg : bus.ldr_req;

  // Reset to loader so the core wins the first tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_owner_reg <= 1'b1;
    end else if (state_reg == IDLE && any_req) begin
      last_owner_reg <= winner;
    end
  end
`endif

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE:   state_next = cmd_we_reg ? IDLE : WAIT;
      WAIT:    if (last_wait) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: memory command only in ISSUE, pulses steered to the owner.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    gnt_vec       = 2'b00;
    rvalid_vec    = 2'b00;
    case (state_reg)
      ISSUE: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = cmd_we_reg;
        bus.mem_addr  = cmd_addr_reg;
        bus.mem_wdata = cmd_wdata_reg;
        gnt_vec       = {owner_reg, ~owner_reg};
      end
      RESP:    rvalid_vec = {owner_reg, ~owner_reg};
      default: ;
    endcase
  end

  assign bus.core_gnt    = gnt_vec[0];
  assign bus.ldr_gnt     = gnt_vec[1];
  assign bus.core_rvalid = rvalid_vec[0];
  assign bus.ldr_rvalid  = rvalid_vec[1];

  // Stall releases on a store's grant or a load's response.
  assign bus.core_stall = bus.core_req & ~(gnt_vec[0] & bus.core_we) & ~rvalid_vec[0];

  // Command register and latency counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_reg     <= 1'b0;
      cmd_we_reg    <= 1'b0;
      cmd_addr_reg  <= '0;
      cmd_wdata_reg <= '0;
      cnt_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            owner_reg     <= winner;
            cmd_we_reg    <= winner ? bus.ldr_we    : bus.core_we;
            cmd_addr_reg  <= winner ? bus.ldr_addr  : bus.core_addr;
            cmd_wdata_reg <= winner ? bus.ldr_wdata : bus.core_wdata;
          end
        end
        ISSUE:   if (!cmd_we_reg) cnt_reg <= LAT_LOAD;
        WAIT:    cnt_reg <= cnt_dec;
        default: ;
      endcase
    end
  end

  // Per-port read data registers; each holds until its owner's next read.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
    localparam logic PORT_ID = 1'(gi);
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        rdata_reg <= '0;
      end else if (last_wait && owner_reg == PORT_ID) begin
        rdata_reg <= bus.mem_rdata;
      end
    end
  end

  assign bus.core_rdata = g_rdata[0].rdata_reg;
  assign bus.ldr_rdata  = g_rdata[1].rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Two arbiter instances: bus1/dut1 with MEM_LAT=1 and bus3/dut3 with
// MEM_LAT=3, each backed by a small behavioural memory with that latency.
// Directed vectors with hand-computed expectations; cycle k is the
// interval after the k-th rising edge counted from the request.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
  logic clock;
  logic reset1;
  logic reset3;
  int   n_checks;
  int   n_pass;

  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();
  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus3 ();

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1)) dut1 (
    .clock (clock),
    .reset (reset1),
    .bus   (bus1)
  );

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3)) dut3 (
    .clock (clock),
    .reset (reset3),
    .bus   (bus3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Latency-1 memory
  logic [7:0] mem1 [256];
  logic [7:0] rd1;
  always @(posedge clock) begin
    if (bus1.mem_en && bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
    rd1 <= mem1[bus1.mem_addr];
  end
  assign bus1.mem_rdata = rd1;

  // Latency-3 memory
  logic [7:0] mem3 [256];
  logic [7:0] p3_0, p3_1, p3_2;
  always @(posedge clock) begin
    if (bus3.mem_en && bus3.mem_we) mem3[bus3.mem_addr] <= bus3.mem_wdata;
    p3_0 <= mem3[bus3.mem_addr];
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign bus3.mem_rdata = p3_2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    #3;
  endtask

  logic [1:0] exp_gnt;
  logic       quiet_bad;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset1   = 1'b0;
    reset3   = 1'b0;
    bus1.core_req = 1'b0; bus1.core_we = 1'b0; bus1.core_addr = '0; bus1.core_wdata = '0;
    bus1.ldr_req  = 1'b0; bus1.ldr_we  = 1'b0; bus1.ldr_addr  = '0; bus1.ldr_wdata  = '0;
    bus3.core_req = 1'b0; bus3.core_we = 1'b0; bus3.core_addr = '0; bus3.core_wdata = '0;
    bus3.ldr_req  = 1'b0; bus3.ldr_we  = 1'b0; bus3.ldr_addr  = '0; bus3.ldr_wdata  = '0;

    // ---- Reset state ----
    #2;
    bus1.core_req = 1'b1;
    #1;
    check("rst_stall_follows_req1", 32'(bus1.core_stall), 32'd1);
    bus1.core_req = 1'b0;
    #1;
    check("rst_stall_follows_req0", 32'(bus1.core_stall), 32'd0);
    check("rst_pulses", 32'({bus1.core_gnt, bus1.core_rvalid, bus1.ldr_gnt, bus1.ldr_rvalid}), 32'd0);
    check("rst_mem_cmd", 32'({bus1.mem_en, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata}), 32'd0);
    check("rst_rdata", 32'({bus1.core_rdata, bus1.ldr_rdata}), 32'd0);
    @(negedge clock);
    reset1 = 1'b1;
    reset3 = 1'b1;

    // ---- Core write 0x05 <= 0xA7, then read back (MEM_LAT=1) ----
    next_cycle();
    $display("txn dut1 core write addr=0x05 data=0xa7");
    bus1.core_req = 1'b1; bus1.core_we = 1'b1; bus1.core_addr = 8'h05; bus1.core_wdata = 8'hA7;
    sample();
    check("wr_c0_stall", 32'(bus1.core_stall), 32'd1);
    check("wr_c0_gnt", 32'(bus1.core_gnt), 32'd0);
    next_cycle();
    sample();
    check("wr_c1_gnt", 32'(bus1.core_gnt), 32'd1);
    check("wr_c1_mem", 32'({bus1.mem_en, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata}), 32'h305A7);
    check("wr_c1_stall", 32'(bus1.core_stall), 32'd0);
    next_cycle();
    $display("txn dut1 core read addr=0x05");
    bus1.core_we = 1'b0;
    sample();
    check("wr_c2_mem_en", 32'(bus1.mem_en), 32'd0);
    check("rd_c0_stall", 32'(bus1.core_stall), 32'd1);
    next_cycle();
    sample();
    check("rd_c1_gnt", 32'(bus1.core_gnt), 32'd1);
    check("rd_c1_mem", 32'({bus1.mem_en, bus1.mem_we, bus1.mem_addr}), 32'h205);
    check("rd_c1_stall", 32'(bus1.core_stall), 32'd1);
    next_cycle();
    sample();
    check("rd_c2_rvalid", 32'(bus1.core_rvalid), 32'd0);
    next_cycle();
    sample();
    check("rd_c3_rvalid", 32'(bus1.core_rvalid), 32'd1);
    check("rd_c3_rdata", 32'(bus1.core_rdata), 32'hA7);
    check("rd_c3_stall", 32'(bus1.core_stall), 32'd0);
    next_cycle();
    bus1.core_req = 1'b0;
    sample();
    check("rd_c4_rvalid", 32'(bus1.core_rvalid), 32'd0);

    // ---- Core read with loader write arriving during WAIT ----
    next_cycle();
    $display("txn dut1 core read addr=0x05, loader write 0x05<=0x99 during WAIT");
    bus1.core_req = 1'b1; bus1.core_we = 1'b0; bus1.core_addr = 8'h05;
    next_cycle();
    sample();
    check("ov_c1_core_gnt", 32'(bus1.core_gnt), 32'd1);
    next_cycle();
    bus1.ldr_req = 1'b1; bus1.ldr_we = 1'b1; bus1.ldr_addr = 8'h05; bus1.ldr_wdata = 8'h99;
    sample();
    check("ov_c2_ldr_gnt", 32'(bus1.ldr_gnt), 32'd0);
    next_cycle();
    sample();
    check("ov_c3_core_rvalid", 32'(bus1.core_rvalid), 32'd1);
    check("ov_c3_core_rdata", 32'(bus1.core_rdata), 32'hA7);
    check("ov_c3_ldr_gnt_mem", 32'({bus1.ldr_gnt, bus1.mem_en}), 32'd0);
    next_cycle();
    bus1.core_req = 1'b0;
    sample();
    check("ov_c4_ldr_gnt_mem", 32'({bus1.ldr_gnt, bus1.mem_en}), 32'd0);
    next_cycle();
    sample();
    check("ov_c5_ldr_gnt", 32'(bus1.ldr_gnt), 32'd1);
    check("ov_c5_mem", 32'({bus1.mem_en, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata}), 32'h30599);
    next_cycle();
    bus1.ldr_req = 1'b0;
    sample();
    check("ov_c6_core_rdata", 32'(bus1.core_rdata), 32'hA7);

    // ---- Asynchronous reset clears held read data ----
    #1;
    reset1 = 1'b0;
    #1;
    check("rst_async_core_rdata", 32'(bus1.core_rdata), 32'd0);

    // ---- Both ports write continuously from reset ----
    $display("txn dut1 both ports writing continuously");
    bus1.core_req = 1'b1; bus1.core_we = 1'b1; bus1.core_addr = 8'h10; bus1.core_wdata = 8'h11;
    bus1.ldr_req  = 1'b1; bus1.ldr_we  = 1'b1; bus1.ldr_addr  = 8'h20; bus1.ldr_wdata  = 8'h22;
    @(negedge clock);
    reset1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      sample();
      if (k % 2 == 0) exp_gnt = 2'b00;
`ifdef DMEM_ARB_CORE_PRIO_EN
      else exp_gnt = 2'b10;
`else
      else exp_gnt = (k % 4 == 1) ? 2'b10 : 2'b01;
`endif
      check($sformatf("rr_c%0d_gnt", k), 32'({bus1.core_gnt, bus1.ldr_gnt}), 32'(exp_gnt));
    end
    next_cycle();
    bus1.core_req = 1'b0;
    bus1.ldr_req  = 1'b0;

    // ---- MEM_LAT=3: loader write 0xFF <= 0x3C then read it ----
    $display("txn dut3 loader write addr=0xff data=0x3c");
    bus3.ldr_req = 1'b1; bus3.ldr_we = 1'b1; bus3.ldr_addr = 8'hFF; bus3.ldr_wdata = 8'h3C;
    next_cycle();
    sample();
    check("l3_wr_gnt", 32'(bus3.ldr_gnt), 32'd1);
    next_cycle();
    $display("txn dut3 loader read addr=0xff");
    bus3.ldr_we = 1'b0;
    next_cycle();
    sample();
    check("l3_rd_c1_gnt", 32'(bus3.ldr_gnt), 32'd1);
    check("l3_rd_c1_mem", 32'({bus3.mem_en, bus3.mem_we, bus3.mem_addr}), 32'h2FF);
    for (int k = 2; k <= 4; k++) begin
      next_cycle();
      sample();
      check($sformatf("l3_rd_c%0d_rvalid", k), 32'(bus3.ldr_rvalid), 32'd0);
    end
    next_cycle();
    sample();
    check("l3_rd_c5_rvalid", 32'(bus3.ldr_rvalid), 32'd1);
    check("l3_rd_c5_rdata", 32'(bus3.ldr_rdata), 32'h3C);
    check("l3_core_quiet", 32'({bus3.core_gnt, bus3.core_rvalid, bus3.core_rdata, bus3.core_stall}), 32'd0);
    next_cycle();
    bus3.ldr_req = 1'b0;

    // ---- Reset during WAIT of a core read ----
    next_cycle();
    $display("txn dut3 core read addr=0xff aborted by reset");
    bus3.core_req = 1'b1; bus3.core_we = 1'b0; bus3.core_addr = 8'hFF;
    next_cycle();
    sample();
    check("ab_c1_gnt", 32'(bus3.core_gnt), 32'd1);
    next_cycle();
    #1;
    reset3 = 1'b0;
    #1;
    check("ab_outs", 32'({bus3.core_gnt, bus3.core_rvalid, bus3.ldr_gnt, bus3.ldr_rvalid,
                          bus3.mem_en, bus3.mem_we, bus3.mem_addr, bus3.mem_wdata}), 32'd0);
    check("ab_rdata", 32'({bus3.core_rdata, bus3.ldr_rdata}), 32'd0);
    check("ab_stall", 32'(bus3.core_stall), 32'd1);
    bus3.core_req = 1'b0;
    @(negedge clock);
    reset3 = 1'b1;
    quiet_bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      sample();
      if (bus3.core_rvalid || bus3.ldr_rvalid || bus3.core_gnt || bus3.ldr_gnt || bus3.mem_en)
        quiet_bad = 1'b1;
    end
    check("ab_quiet_after_release", 32'(quiet_bad), 32'd0);
    next_cycle();
    $display("txn dut3 loader write addr=0x00 data=0x55 after abort");
    bus3.ldr_req = 1'b1; bus3.ldr_we = 1'b1; bus3.ldr_addr = 8'h00; bus3.ldr_wdata = 8'h55;
    next_cycle();
    sample();
    check("ab_idle_then_gnt", 32'(bus3.ldr_gnt), 32'd1);
    check("ab_idle_then_mem", 32'({bus3.mem_en, bus3.mem_we, bus3.mem_addr, bus3.mem_wdata}), 32'h30055);
    next_cycle();
    bus3.ldr_req = 1'b0;
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
